// File: rtl/vga_pkg.sv
// Shared definitions for the pixel path: pacing FSM states and default byte width.
package vga_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_mem.sv
// Storage for the receive FIFO: synchronous write, combinational read, no reset.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Queues bytes from the UART receiver and releases them one at a time,
// pacing each release on the transmitter's busy handshake (with a timeout).
module uart_rx_fifo
    import vga_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = 4,
    parameter int BUSY_TO = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_done,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tx_busy,
    output logic              pix_en,
    output logic [DATA_W-1:0] pix_data,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);

    localparam int            DEPTH = 2**ADDR_W;
    localparam int            TO_W  = $clog2(BUSY_TO + 1);
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(BUSY_TO - 1);

    logic              r_rx_prev;
    logic              r_push;
    logic [DATA_W-1:0] r_rx_data;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_overflow;
    logic              r_pix_en;
    logic [DATA_W-1:0] r_pix_data;
    logic [TO_W-1:0]   r_to_cnt;
    state_t            r_state;

    logic              w_full;
    logic              w_pop;
    logic              w_wr_en;
    logic              w_drop;
    logic [DATA_W-1:0] w_rdata;

    assign w_full  = (r_level == FULL_LVL);
    assign w_pop   = (r_state == ST_IDLE) && (r_level != '0) && !tx_busy;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign w_wr_en = r_push && (!w_full || w_pop);
    assign w_drop  = r_push && w_full && !w_pop;

    fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (r_rx_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Edge detect starts at 1 so a receiver already high out of reset is not a new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_prev <= 1'b1;
            r_push    <= 1'b0;
            r_rx_data <= '0;
        end else begin
            r_rx_prev <= rx_done;
            r_push    <= rx_done && !r_rx_prev;
            if (rx_done && !r_rx_prev) begin
                r_rx_data <= rx_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_en && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_wr_en && w_pop) begin
                r_level <= r_level - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pix_en   <= 1'b0;
            r_pix_data <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_pix_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state    <= ST_LAUNCH;
                        r_pix_en   <= 1'b1;
                        r_pix_data <= w_rdata;
                    end
                end
                ST_LAUNCH: begin
                    r_state  <= ST_WAIT_HI;
                    r_to_cnt <= '0;
                end
                ST_WAIT_HI: begin
                    if (tx_busy) begin
                        r_state <= ST_WAIT_LO;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_WAIT_LO: begin
                    if (!tx_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pix_en   = r_pix_en;
    assign pix_data = r_pix_data;
    assign level    = r_level;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo: a byte queue models expected output order and loss.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_done = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       tx_busy = 1'b0;
    logic       pix_en;
    logic [7:0] pix_data;
    logic [4:0] level;
    logic       overflow;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   phase = 0;
    int   pix_total = 0;
    bit   exp_ovf = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_fifo dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_done  (rx_done),
        .rx_data  (rx_data),
        .tx_busy  (tx_busy),
        .pix_en   (pix_en),
        .pix_data (pix_data),
        .level    (level),
        .overflow (overflow)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: every launched byte must be the oldest accepted byte still queued.
    initial begin : monitor
        int  mon_phase = 0;
        bit  have_last = 1'b0;
        int  last_cyc = 0;
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (phase != mon_phase) begin
                mon_phase = phase;
                have_last = 1'b0;
            end
            if (pix_en) begin
                pix_total++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pix_en", {24'h0, pix_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("pix_data", {24'h0, pix_data}, {24'h0, exp_b});
                    $display("pix_en cycle %0d data %02h", cyc, pix_data);
                end
                if (mon_phase == 2) begin
                    check("pulse_busy_low", {31'h0, tx_busy}, 32'h0);
                    if (have_last) check("pulse_gap_ge53", (cyc - last_cyc) >= 53, 1);
                end
                if (mon_phase == 3 && have_last) begin
                    check("timeout_gap_ge17", (cyc - last_cyc) >= 17, 1);
                end
                have_last = 1'b1;
                last_cyc  = cyc;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data = b;
        rx_done = 1'b1;
        if (exp_q.size() < 16) exp_q.push_back(b);
        else exp_ovf = 1'b1;
        repeat (2) @(posedge clk);
        #1 rx_done = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_pix(input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pix_en && n < budget);
        if (!pix_en) check(tag, 0, 1);
    endtask

    initial begin : main
        int lat;
        int base;
        logic [7:0] b;

        // Reset with rx_done held high: no push on release.
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("rst_level", {27'h0, level}, 0);
        check("rst_overflow", {31'h0, overflow}, 0);
        check("rst_pix_data", {24'h0, pix_data}, 0);
        check("rst_no_pix", pix_total, 0);
        rx_done = 1'b0;
        repeat (3) @(posedge clk);

        // Single byte latency.
        @(posedge clk);
        #1;
        rx_data = 8'h5A;
        rx_done = 1'b1;
        exp_q.push_back(8'h5A);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (pix_en && lat == 0) lat = k;
        end
        check("latency", lat, 3);
        check("latency_data", {24'h0, pix_data}, 32'h5A);
        rx_done = 1'b0;
        wait_drain(200);
        check("single_level", {27'h0, level}, 0);

        // Burst of 20 with busy held: 16 kept, 4 dropped.
        tx_busy = 1'b1;
        base = pix_total;
        for (int i = 0; i < 20; i++) send_byte(8'(i));
        @(negedge clk);
        check("burst_level", {27'h0, level}, 16);
        check("burst_overflow", {31'h0, overflow}, {31'h0, exp_ovf});
        tx_busy = 1'b0;
        wait_drain(2000);
        check("burst_count", pix_total - base, 16);
        check("burst_drained", {27'h0, level}, 0);
        check("overflow_sticky", {31'h0, overflow}, 1);

        // Busy pulses of 50 cycles two cycles after each launch.
        phase = 2;
        tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        @(negedge clk);
        check("pulse_level", {27'h0, level}, 4);
        tx_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_pix(500, "pulse_wait_timeout");
            @(posedge clk);
            @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat (50) @(posedge clk);
            #1 tx_busy = 1'b0;
        end
        wait_drain(500);

        // Busy never rises: timeout pacing, 40 random bytes across pointer wrap.
        phase = 3;
        base = pix_total;
        for (int i = 0; i < 40; i++) begin
            while (exp_q.size() >= 8) @(posedge clk);
            repeat ($urandom_range(0, 20)) @(posedge clk);
            send_byte(8'($urandom));
        end
        wait_drain(2000);
        check("timeout_count", pix_total - base, 40);
        check("timeout_level", {27'h0, level}, 0);

        // Reset while in WAIT_LO with 5 bytes queued.
        phase = 4;
        send_byte(8'hA1);
        wait_pix(200, "rstphase_wait_timeout");
        tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        @(negedge clk);
        check("wlo_level", {27'h0, level}, 5);
        @(posedge clk);
        #3 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_level", {27'h0, level}, 0);
        check("midrst_overflow", {31'h0, overflow}, 0);
        check("midrst_pix_en", {31'h0, pix_en}, 0);
        base = pix_total;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tx_busy = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("post_rst_no_pix", pix_total - base, 0);
        check("post_rst_level", {27'h0, level}, 0);
        b = 8'h3C;
        send_byte(b);
        wait_drain(200);
        check("post_rst_count", pix_total - base, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
